// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// FSM state codes, default operand width and the step-counter width helper.
package shift_add_mult_ctrl_pkg;

  localparam int MULT_DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Operand start/ready and product valid/ack bundle for shift_add_mult_ctrl.
// master = operand source / product consumer, slave = multiplier controller.
interface shift_add_mult_ctrl_if
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_DEFAULT_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic               ready;
  logic               busy;
  logic               p_valid;
  logic               p_ack;
  logic [2*WIDTH-1:0] p;

  modport master (
    output start, m, q, p_ack,
    input  ready, busy, p_valid, p
  );

  modport slave (
    input  start, m, q, p_ack,
    output ready, busy, p_valid, p
  );

endinterface

// File: rtl/shift_add_mult_ctrl_ripple_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of 1-bit full adders;
// the single adder shared by every step of the sequential multiplier.
module ripple_adder
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier: one add/shift step per clock.
// Optional MULT_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = MULT_DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_mult_ctrl_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   step_aq;
  logic [2*WIDTH-1:0]   next_aq;
  logic                 last_step;
  logic                 finish;

  assign addend = q_q[0] ? m_q : '0;

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (a_q),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Right shift of {carry,sum,Q} by one; the carry lands in A's MSB.
  assign step_aq   = {carry, sum, q_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MULT_EARLY_EXIT_EN
  logic [WIDTH-1:0]     rem_mask;
  logic                 rem_zero;
  logic [CNT_W-1:0]     exit_sh;
  logic [2*WIDTH-1:0]   exit_aq;

  // Low WIDTH-cnt bits of Q are the multiplier bits not yet consumed.
  assign rem_mask = {WIDTH{1'b1}} >> cnt_q;
  assign rem_zero = ~|(q_q & rem_mask);
  assign exit_sh  = CNT_W'(WIDTH) - cnt_q;
  assign exit_aq  = {a_q, q_q} >> exit_sh;
  assign finish   = last_step | rem_zero;
  assign next_aq  = rem_zero ? exit_aq : step_aq;
`else
  assign finish   = last_step;
  assign next_aq  = step_aq;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          m_d     = bus.m;
          q_d     = bus.q;
          a_d     = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        {a_d, q_d} = next_aq;
        cnt_d      = cnt_q + 1'b1;
        if (finish) begin
          p_d     = next_aq;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.p_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  assign bus.ready   = (state_q == ST_IDLE);
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.p_valid = (state_q == ST_DONE);
  assign bus.p       = p_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl (WIDTH=4): directed and random operations
// compared against an arithmetic product/latency model.
module tb_shift_add_mult_ctrl;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  shift_add_mult_ctrl_if #(.WIDTH(W)) bus ();

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int passes = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges from accept to p_valid, derived from the multiplier value alone.
  function automatic int model_latency(input int qv);
`ifdef MULT_EARLY_EXIT_EN
    int msb;
    if (qv == 0) return 1;
    msb = 0;
    for (int b = 0; b < W; b++) if (qv[b]) msb = b;
    return (msb + 2 < W) ? msb + 2 : W;
`else
    return W + 0 * qv;
`endif
  endfunction

  task automatic run_op(input int mv, input int qv, input int ack_delay,
                        input bit inject, input string tag);
    int n;
    int busy_cnt;
    int prod;
    prod = mv * qv;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, ":ready_before"}, 32'(bus.ready), 32'd1);
    bus.m     = W'(mv);
    bus.q     = W'(qv);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ":busy_after_accept"}, 32'(bus.busy), 32'd1);
    if (inject) begin
      bus.start = 1'b1;
      bus.m     = W'(2);
      bus.q     = W'(2);
    end
    n = 0;
    busy_cnt = 0;
    while (bus.p_valid !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1 && bus.ready === 1'b0) busy_cnt++;
      tick();
      n++;
    end
    check({tag, ":latency"}, 32'(n), 32'(model_latency(qv)));
    check({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(model_latency(qv)));
    check({tag, ":product"}, 32'(bus.p), 32'(prod));
    check({tag, ":ready_in_done"}, 32'(bus.ready), 32'd0);
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      check({tag, ":hold_valid"}, 32'(bus.p_valid), 32'd1);
      check({tag, ":hold_p"}, 32'(bus.p), 32'(prod));
    end
    bus.p_ack = 1'b1;
    tick();
    bus.p_ack = 1'b0;
    bus.start = 1'b0;
    check({tag, ":valid_after_ack"}, 32'(bus.p_valid), 32'd0);
    check({tag, ":ready_after_ack"}, 32'(bus.ready), 32'd1);
    check({tag, ":p_retained"}, 32'(bus.p), 32'(prod));
    if (inject) check({tag, ":start_dropped"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.m     = '0;
    bus.q     = '0;
    bus.p_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset:ready", 32'(bus.ready), 32'd1);
    check("reset:busy", 32'(bus.busy), 32'd0);
    check("reset:p_valid", 32'(bus.p_valid), 32'd0);
    check("reset:p", 32'(bus.p), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    run_op(13, 11, 0, 1'b0, "basic");
    run_op(15, 15, 0, 1'b0, "max");
    run_op(0, 9, 0, 1'b0, "zero_m");
    run_op(6, 7, 10, 1'b0, "hold_ack");
    run_op(9, 10, 1, 1'b1, "start_in_run");

    // Abort an operation with an asynchronous reset in its second RUN cycle.
    bus.m     = W'(7);
    bus.q     = W'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("midreset:ready", 32'(bus.ready), 32'd1);
    check("midreset:busy", 32'(bus.busy), 32'd0);
    check("midreset:p_valid", 32'(bus.p_valid), 32'd0);
    check("midreset:p", 32'(bus.p), 32'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midreset:no_valid", 32'(bus.p_valid), 32'd0);
    end
    run_op(3, 6, 0, 1'b0, "after_reset");

    run_op(9, 0, 0, 1'b0, "q_zero");
    run_op(12, 1, 0, 1'b0, "q_one");
    run_op(5, 8, 0, 1'b0, "q_eight");

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)), 1'b0, "random");

    for (int mv = 0; mv < 16; mv++)
      for (int qv = 0; qv < 16; qv++)
        run_op(mv, qv, 0, 1'b0, "sweep");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
